key_repeat: RTL and testbench
=============================

Name: key_repeat

Overview:
- Sits directly downstream of the button debouncer. It consumes the clean, registered level and produces press events for the CPU I/O logic.
- Emits one single-cycle pulse per press. If the key is held, it emits further pulses (typematic auto-repeat) after an initial hold delay, then at a fixed rate.
- Keeps an 8-bit event count so simple polled software can detect presses without ever missing one.

Parameters:
- CNT_W, 24, width of the internal timing counter; must hold max(HOLD, RATE)-1.
- HOLD, 12500000, clock cycles from the first pulse to the first repeat pulse; HOLD >= 2.
- RATE, 2500000, clock cycles between consecutive repeat pulses; RATE >= 2.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in  input  1  debounced key level, 1 = pressed; synchronous to clk.
- clr  input  1  synchronous clear of count.
- pulse  output  1  one-cycle press/repeat event, registered.
- held  output  1  high while in auto-repeat (REPEAT state), registered.
- count  output  8  number of pulses emitted, modulo 256, registered.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, timing counter=0, in_q=0, pulse=0, held=0, count=0.
- in_q is registered from in every cycle. A rise is detected at an edge where in=1 and in_q=0.
- Edge N is defined as the edge at which a rise is detected.
- State IDLE:
  - On rise: pulse=1 for one cycle (from edge N to edge N+1), state->WAIT, timing counter=0.
  - Otherwise pulse=0.
- State WAIT:
  - If in=0: state->IDLE, timing counter=0, no pulse.
  - Else if counter==HOLD-1: pulse=1, state->REPEAT, counter=0.
  - Else counter+1.
  - Result: the first repeat pulse is at edge N+HOLD.
- State REPEAT (held=1):
  - If in=0: state->IDLE, held=0, counter=0, no pulse.
  - Else if counter==RATE-1: pulse=1, counter=0.
  - Else counter+1.
  - Result: repeat pulses at edges N+HOLD+k*RATE, k>=1.
- pulse is 0 on every edge not listed above, so it is never high for two consecutive cycles.
- held goes 1 on the same edge as the first repeat pulse, and goes 0 on the edge where release is sampled.
- count: +1 (8-bit wrap, 255->0) on every edge where pulse is asserted.
  - clr=1 forces count=0 and has priority over a simultaneous pulse. The pulse itself is still emitted.
- Release timing: release followed by re-press one cycle later is a fresh rise in IDLE, giving a new pulse and a new HOLD wait.
- in already high at reset release: in_q=0, so the first edge counts as a rise and a pulse is emitted.
- Reset mid-hold: all state is cleared immediately. The next edge with in=1 counts as a new rise.
- in=1 in IDLE with in_q=1 (no rise): stay in IDLE. This case is reachable only transiently.
- Timing counter never exceeds max(HOLD,RATE)-1; no overflow is possible.

Test Plan:
(Sim parameters for all scenarios: HOLD=8, RATE=4.)
- Reset: hold rst_n=0 with in=1 and clr=0 -> pulse=0, held=0, count=0. Release reset -> pulse on the first edge, count=1.
- Short press: in high for 5 cycles -> exactly one pulse at edge N, held stays 0, count=1. State returns to IDLE on the edge where in=0 is sampled.
- Long press: in high for 20 cycles -> pulses at N, N+8, N+12, N+16, N+20 if still high. held=1 from N+8. count=4 or 5 matching the pulses.
- Release in REPEAT then re-press one cycle later -> held drops, a new pulse appears at the rise edge, and the next repeat is again 8 cycles later.
- Wrap and clear: generate 256 pulses -> count=0. Assert clr on the same edge as a pulse -> count=0 and pulse still seen. Next pulse -> count=1.
- Async reset mid-REPEAT (rst_n low between edges) -> pulse, held and count go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/key_repeat_if.sv
// key_repeat_if: key level/clear in, press events/hold flag/event count out.
// Ports: i_in (debounced key level), i_clr (sync count clear),
//        o_pulse (one-cycle press/repeat event), o_held (auto-repeat active),
//        o_count (8-bit pulse count, wraps).
interface key_repeat_if;
  logic       i_in;
  logic       i_clr;
  logic       o_pulse;
  logic       o_held;
  logic [7:0] o_count;
  modport master (output i_in, i_clr, input o_pulse, o_held, o_count);
  modport slave (input i_in, i_clr, output o_pulse, o_held, o_count);
endinterface

// File: rtl/key_repeat.sv
// key_repeat: typematic auto-repeat press-event generator with a wrapping event count.
// Ports: clk, rst_n (async active-low), bus (slave: i_in, i_clr -> o_pulse, o_held, o_count).
module key_repeat #(
  parameter int CNT_W = 24,
  parameter int HOLD  = 12500000,
  parameter int RATE  = 2500000
) (
  input  logic        clk,
  input  logic        rst_n,
  key_repeat_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, REPEAT} state_t;
  state_t     r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic       r_in_q, r_pulse, r_held, w_pulse, w_rise;
  logic [7:0] r_count;
  assign w_rise = bus.i_in & ~r_in_q;
  always_comb begin
    w_next  = r_state;
    w_cnt   = '0;
    w_pulse = 1'b0;
    case (r_state)
      IDLE: if (w_rise) begin
        w_pulse = 1'b1;
        w_next  = WAIT;
      end
      WAIT:
        if (!bus.i_in) w_next = IDLE;
        else if (r_cnt == CNT_W'(HOLD - 1)) begin
          w_pulse = 1'b1;
          w_next  = REPEAT;
        end else w_cnt = r_cnt + 1'b1;
      REPEAT:
        if (!bus.i_in) w_next = IDLE;
        else if (r_cnt == CNT_W'(RATE - 1)) w_pulse = 1'b1;
        else w_cnt = r_cnt + 1'b1;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_in_q  <= 1'b0;
      r_pulse <= 1'b0;
      r_held  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_in_q  <= bus.i_in;
      r_pulse <= w_pulse;
      r_held  <= (w_next == REPEAT);
      // clear wins over a simultaneous pulse; the pulse itself still goes out
      r_count <= bus.i_clr ? 8'd0 : w_pulse ? r_count + 8'd1 : r_count;
    end
  end
  assign bus.o_pulse = r_pulse;
  assign bus.o_held  = r_held;
  assign bus.o_count = r_count;
endmodule

// File: tb/tb_key_repeat.sv
// tb_key_repeat: directed self-checking bench for key_repeat with HOLD=8, RATE=4.
module tb_key_repeat;
  logic clk = 1'b0;
  logic rst_n;
  int ncmp = 0;
  int nerr = 0;
  logic [7:0] exp_cnt;
  key_repeat_if bus ();
  key_repeat #(.CNT_W(4), .HOLD(8), .RATE(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    bus.i_in = 1'b1;
    bus.i_clr = 1'b0;
    #1;
    chk("rst_pulse", {7'd0, bus.o_pulse}, 8'd0);
    chk("rst_held", {7'd0, bus.o_held}, 8'd0);
    chk("rst_count", bus.o_count, 8'd0);
    tick();
    chk("rst_hold_pulse", {7'd0, bus.o_pulse}, 8'd0);
    rst_n = 1'b1;
    tick();
    chk("first_edge_pulse", {7'd0, bus.o_pulse}, 8'd1);
    chk("first_edge_count", bus.o_count, 8'd1);
    bus.i_in = 1'b0;
    tick();
    chk("release_pulse", {7'd0, bus.o_pulse}, 8'd0);
    exp_cnt = 8'd1;
    // short press: five cycles high
    bus.i_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) exp_cnt++;
      chk($sformatf("short_pulse_%0d", k), {7'd0, bus.o_pulse}, {7'd0, k == 0});
      chk($sformatf("short_held_%0d", k), {7'd0, bus.o_held}, 8'd0);
    end
    bus.i_in = 1'b0;
    tick();
    chk("short_end_pulse", {7'd0, bus.o_pulse}, 8'd0);
    chk("short_count", bus.o_count, exp_cnt);
    // long press: edges N..N+20 all sample in=1
    bus.i_in = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      logic p;
      tick();
      p = (k == 0 || k == 8 || k == 12 || k == 16 || k == 20);
      if (p) exp_cnt++;
      chk($sformatf("long_pulse_%0d", k), {7'd0, bus.o_pulse}, {7'd0, p});
      chk($sformatf("long_held_%0d", k), {7'd0, bus.o_held}, {7'd0, k >= 8});
    end
    chk("long_count", bus.o_count, exp_cnt);
    // release in REPEAT, re-press one cycle later
    bus.i_in = 1'b0;
    tick();
    chk("rel_held", {7'd0, bus.o_held}, 8'd0);
    chk("rel_pulse", {7'd0, bus.o_pulse}, 8'd0);
    bus.i_in = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      logic p;
      tick();
      p = (k == 0 || k == 8);
      if (p) exp_cnt++;
      chk($sformatf("repress_pulse_%0d", k), {7'd0, bus.o_pulse}, {7'd0, p});
      chk($sformatf("repress_held_%0d", k), {7'd0, bus.o_held}, {7'd0, k == 8});
    end
    chk("repress_count", bus.o_count, exp_cnt);
    bus.i_in = 1'b0;
    tick();
    // clear alone, then wrap after 256 pulses
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    chk("clr_count", bus.o_count, 8'd0);
    for (int n = 1; n <= 256; n++) begin
      bus.i_in = 1'b1;
      tick();
      bus.i_in = 1'b0;
      tick();
      if (n == 255) chk("count_255", bus.o_count, 8'd255);
    end
    chk("wrap_count", bus.o_count, 8'd0);
    bus.i_in = 1'b1;
    tick();
    chk("post_wrap_count", bus.o_count, 8'd1);
    bus.i_in = 1'b0;
    tick();
    // clear on a pulse edge: pulse emitted, count cleared
    bus.i_in = 1'b1;
    bus.i_clr = 1'b1;
    tick();
    chk("clr_pulse", {7'd0, bus.o_pulse}, 8'd1);
    chk("clr_pulse_count", bus.o_count, 8'd0);
    bus.i_clr = 1'b0;
    bus.i_in = 1'b0;
    tick();
    bus.i_in = 1'b1;
    tick();
    chk("after_clr_pulse", {7'd0, bus.o_pulse}, 8'd1);
    chk("after_clr_count", bus.o_count, 8'd1);
    // async reset mid-REPEAT: edges N'+1..N'+8 held high, pulse at N'+8
    bus.i_in = 1'b0;
    tick();
    bus.i_in = 1'b1;
    for (int k = 0; k <= 8; k++) tick();
    chk("pre_rst_pulse", {7'd0, bus.o_pulse}, 8'd1);
    chk("pre_rst_held", {7'd0, bus.o_held}, 8'd1);
    chk("pre_rst_count", bus.o_count, 8'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pulse", {7'd0, bus.o_pulse}, 8'd0);
    chk("async_rst_held", {7'd0, bus.o_held}, 8'd0);
    chk("async_rst_count", bus.o_count, 8'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_pulse", {7'd0, bus.o_pulse}, 8'd1);
    chk("post_rst_count", bus.o_count, 8'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
